// File: rtl/coder_pkg.sv
// Shared definitions for the 8-to-3 encoder and 3-to-8 strobe decoder pair.
package coder_pkg;

    localparam int IDX_W    = 3;
    localparam int ONEHOT_W = 8;
    localparam int TIMER_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } decState_t;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable 8-bit down-counter; holds at zero so it can never underflow.
module strobe_timer
    import coder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    input  logic               clr_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/decoder38_strobe.sv
// Registered 3-to-8 one-hot decoder: holds the decoded line for PULSE_LEN cycles,
// then idles GAP_LEN cycles before accepting the next index; tracks a sticky seen mask.
module decoder38_strobe
    import coder_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    dataIn,
    input  logic                validIn,
    output logic                readyOut,
    input  logic                enable,
    input  logic                clearSeen,
    output logic [ONEHOT_W-1:0] dataOut,
    output logic                busy,
    output logic [ONEHOT_W-1:0] seen
);

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? TIMER_W'(GAP_LEN - 1) : '0;
    localparam bit                 HAS_GAP    = (GAP_LEN > 0);

    decState_t           state_q;
    logic [ONEHOT_W-1:0] data_q;
    logic [ONEHOT_W-1:0] seen_q;
    logic [ONEHOT_W-1:0] seen_d;
    logic [ONEHOT_W-1:0] onehot_in;
    logic                transfer;

    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_load_val;
    logic                tmr_en;
    logic                tmr_clr;
    logic                tmr_zero;

    assign readyOut  = enable && !rst && (state_q == IDLE);
    assign transfer  = validIn && readyOut;
    assign onehot_in = onehot(dataIn);

    // One timer serves both PULSE and GAP; the FSM decides what gets loaded.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = PULSE_LOAD;
        tmr_en       = 1'b0;
        tmr_clr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (!enable) begin
                    tmr_clr = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load     = HAS_GAP;
                    tmr_load_val = GAP_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                if (!enable) begin
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: tmr_clr = 1'b1;
        endcase
    end

    // A clear colliding with a transfer keeps only the newly decoded line.
    always_comb begin
        seen_d = seen_q;
        if (transfer) begin
            seen_d = (clearSeen ? '0 : seen_q) | onehot_in;
        end else if (clearSeen) begin
            seen_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            seen_q  <= '0;
        end else begin
            seen_q <= seen_d;
            unique case (state_q)
                IDLE: begin
                    if (transfer) begin
                        data_q  <= onehot_in;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    if (!enable) begin
                        data_q  <= '0;
                        state_q <= IDLE;
                    end else if (tmr_zero) begin
                        data_q  <= '0;
                        state_q <= HAS_GAP ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (!enable || tmr_zero) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    data_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    strobe_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .clr_i      (tmr_clr),
        .zero_o     (tmr_zero)
    );

    assign dataOut = data_q;
    assign seen    = seen_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_decoder38_strobe.sv
// Scoreboard bench: two decoder configurations share one stimulus stream and are
// checked against a timestamp-based reference model.
module tb_decoder38_strobe;

    localparam int PA = 4;
    localparam int GA = 1;
    localparam int PB = 1;
    localparam int GB = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       validIn;
    logic       enable;
    logic       clearSeen;
    logic [2:0] dataIn;

    logic       rdy_a, rdy_b, bsy_a, bsy_b;
    logic [7:0] dout_a, dout_b, seen_a, seen_b;

    always #5 clk = ~clk;

    decoder38_strobe #(.PULSE_LEN(PA), .GAP_LEN(GA)) u_a (
        .clk(clk), .rst(rst), .dataIn(dataIn), .validIn(validIn), .readyOut(rdy_a),
        .enable(enable), .clearSeen(clearSeen), .dataOut(dout_a), .busy(bsy_a), .seen(seen_a)
    );

    decoder38_strobe #(.PULSE_LEN(PB), .GAP_LEN(GB)) u_b (
        .clk(clk), .rst(rst), .dataIn(dataIn), .validIn(validIn), .readyOut(rdy_b),
        .enable(enable), .clearSeen(clearSeen), .dataOut(dout_b), .busy(bsy_b), .seen(seen_b)
    );

    typedef struct packed {
        logic [1:0][7:0] d;
        logic [1:0]      b;
        logic [1:0][7:0] s;
    } exp_t;

    exp_t       out_q[$];
    logic [1:0] ready_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: each instance remembers when its strobe ends and when it is free.
    int         plen[2];
    int         glen[2];
    int         free_e[2];
    int         pend[2];
    logic [7:0] oh_m[2];
    logic [7:0] seen_m[2];
    int         x = 0;

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, k, $time, act, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic en, input logic v,
                       input logic [2:0] d, input logic c);
        exp_t       e;
        logic [1:0] rq;
        logic       ready;
        @(negedge clk);
        rst       = r;
        enable    = en;
        validIn   = v;
        dataIn    = d;
        clearSeen = c;
        x++;
        for (int k = 0; k < 2; k++) begin
            ready = en && !r && (x - 1 >= free_e[k]);
            rq[k] = ready;
            if (r) begin
                free_e[k] = x;
                pend[k]   = x;
                seen_m[k] = 8'h00;
            end else if (ready && v) begin
                oh_m[k]   = 8'(1 << d);
                pend[k]   = x + plen[k];
                free_e[k] = x + plen[k] + glen[k];
                seen_m[k] = (c ? 8'h00 : seen_m[k]) | oh_m[k];
            end else begin
                if (c) seen_m[k] = 8'h00;
                if (!en && (x - 1 < free_e[k])) begin
                    free_e[k] = x;
                    if (pend[k] > x) pend[k] = x;
                end
            end
            e.d[k] = (x < pend[k]) ? oh_m[k] : 8'h00;
            e.b[k] = (x < free_e[k]);
            e.s[k] = seen_m[k];
        end
        ready_q.push_back(rq);
        out_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [1:0] rq;
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                chk("dataOut", 0, dout_a, e.d[0]);
                chk("dataOut", 1, dout_b, e.d[1]);
                chk("busy", 0, {7'd0, bsy_a}, {7'd0, e.b[0]});
                chk("busy", 1, {7'd0, bsy_b}, {7'd0, e.b[1]});
                chk("seen", 0, seen_a, e.s[0]);
                chk("seen", 1, seen_b, e.s[1]);
            end
            @(negedge clk);
            #2;
            if (ready_q.size() > 0) begin
                rq = ready_q.pop_front();
                chk("readyOut", 0, {7'd0, rdy_a}, {7'd0, rq[0]});
                chk("readyOut", 1, {7'd0, rdy_b}, {7'd0, rq[1]});
            end
        end
    end

    initial begin : stimulus
        plen[0] = PA; glen[0] = GA;
        plen[1] = PB; glen[1] = GB;
        for (int k = 0; k < 2; k++) begin
            free_e[k] = 0;
            pend[k]   = 0;
            oh_m[k]   = 8'h00;
            seen_m[k] = 8'h00;
        end
        rst = 1'b1; enable = 1'b1; validIn = 1'b1; dataIn = 3'd5; clearSeen = 1'b0;

        // Reset with validIn asserted, then a single decode of index 5
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Back-to-back with validIn held; dataIn changes while busy
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        repeat (12) cyc(1'b0, 1'b1, 1'b1, 3'd7, 1'b0);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Abort mid-pulse and hold enable low for a while
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Walk every index to fill seen, then clear colliding with a transfer
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 3'(i), 1'b0);
            repeat (6) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 3'd2, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Continuous validIn with a walking index, then reset mid-pulse
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b1, 3'(i / 2), 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 3'd6, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        repeat (3000) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 19) != 0),
                ($urandom_range(0, 9) < 7),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 24) == 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (out_q.size() != 0 || ready_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d output and %0d ready entries left, expected 0",
                     out_q.size(), ready_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder38_strobe.md
# decoder38_strobe

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a timed output strobe; the inverse of the team's 8-to-3 encoder. An accepted 3-bit index drives exactly one of eight strobe lines for a programmable number of cycles, then enforces a programmable idle gap before the next index is accepted. A sticky per-line record of every decoded index is kept for software or debug readout.

## Interface
- PULSE_LEN, default 4: cycles the one-hot strobe is held; legal range 1..255.
- GAP_LEN, default 1: forced idle cycles after each strobe; legal range 0..255.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- dataIn  in  3  index to decode.
- validIn  in  1  dataIn valid.
- readyOut  out  1  block can accept; transfer occurs when validIn && readyOut.
- enable  in  1  global enable; low blocks acceptance and aborts an active strobe.
- clearSeen  in  1  single-cycle clear of seen.
- dataOut  out  8  one-hot strobe, 8'h00 when idle.
- busy  out  1  high in PULSE or GAP.
- seen  out  8  sticky OR of all strobes issued since last clear or reset.

## Operation
- FSM states: IDLE, PULSE, GAP. Reset state IDLE.
- IDLE: readyOut = enable && !rst (combinational). On transfer: dataOut <= 8'h01 << dataIn, state <= PULSE, timer <= PULSE_LEN-1.
- PULSE: dataOut held. Timer decrements each cycle; at timer==0: dataOut <= 0, state <= GAP with timer <= GAP_LEN-1 if GAP_LEN>0, else state <= IDLE.
- GAP: dataOut 0; at timer==0 state <= IDLE.
- readyOut is low in PULSE and GAP; no acceptance in the final PULSE or GAP cycle.
- enable low in PULSE or GAP: next edge dataOut <= 0, timer <= 0, state <= IDLE (abort, no gap). readyOut stays low until enable returns.
- busy = (state != IDLE), registered-state decode.
- seen: on transfer, seen <= seen | onehot(dataIn). clearSeen alone: seen <= 0. clearSeen with transfer in same cycle: seen <= onehot(dataIn) (set wins for the new bit, all others cleared).
- Timer width: 8 bits, unsigned; never underflows (transitions taken at 0).
- dataIn is sampled only on transfer; changes while busy are ignored.
- rst asserted in any state: next edge state IDLE, dataOut 0, seen 0, timer 0; validIn ignored during rst.

## Timing
- Reset values: dataOut 8'h00, seen 8'h00, busy 0, readyOut 0 while rst high.
- Latency: transfer at edge N makes dataOut valid from cycle N+1 through N+PULSE_LEN inclusive.
- Gap: dataOut 0 for cycles N+PULSE_LEN+1 .. N+PULSE_LEN+GAP_LEN; readyOut high at N+PULSE_LEN+GAP_LEN+1.
- Minimum transfer period: PULSE_LEN+GAP_LEN+1 cycles.
- seen updates at same edge dataOut is loaded.
- Abort: enable low sampled at edge M clears dataOut at M+1.

## Structure
- Shared package coder_pkg: IDX_W = 3, ONEHOT_W = 8, typedef enum logic [1:0] decState_t {IDLE, PULSE, GAP}; encoder and decoder both import it.
- One sub-module: strobe_timer (8-bit loadable down-counter with load, enable, clear, zero flag), instantiated once and shared by PULSE and GAP.
- FSM, one-hot decode and seen register in the top module.

## Test plan
- Reset: rst high 2 cycles with validIn=1 -> no transfer; dataOut=8'h00, seen=8'h00, busy=0; readyOut=1 first cycle after rst low with enable=1.
- Single decode, PULSE_LEN=4, GAP_LEN=1: dataIn=5 accepted at N -> dataOut=8'h20 cycles N+1..N+4, 8'h00 at N+5, readyOut=1 at N+6; dataOut fed to encoder83 returns 3'b101.
- Back-to-back: validIn held, dataIn=3 then 7 -> second transfer at N+6, dataOut=8'h80 cycles N+7..N+10; seen=8'h88.
- Abort: dataIn=0 accepted at N, enable low at N+2 -> dataOut=8'h00 at N+3, busy=0, readyOut=0 until enable high, then 1 same cycle.
- Clear collision: seen=8'hFF, clearSeen=1 with transfer of dataIn=2 -> seen=8'h04.
- GAP_LEN=0, PULSE_LEN=1: continuous validIn, indices 0..7 -> one transfer every 2 cycles, dataOut walks 8'h01..8'h80, seen=8'hFF; rst mid-pulse -> dataOut=8'h00 next cycle.
